// File: rtl/sram_dmem_bridge_pkg.sv
// Shared definitions for the CPU data-port to 8-bit SRAM bridge:
// FSM state encodings, lane geometry and the lane priority encoder.
package sram_dmem_bridge_pkg;

  localparam int NUM_LANES = 4;
  localparam int BYTE_W    = 8;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Lowest set lane of a byte mask; an empty mask maps to lane 0.
  function automatic logic [1:0] lowest_lane(input logic [NUM_LANES-1:0] m);
    logic [1:0] l;
    l = 2'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (m[i]) l = 2'(i);
    return l;
  endfunction

endpackage

// File: rtl/sram_dmem_bridge_if.sv
// Bus bundle between CPU data port, bridge and external SRAM pins.
//   CPU side : i_daddr, i_dout, i_ram_rd, i_ram_wr -> bridge; o_din, o_clk_en <- bridge
//   SRAM side: o_sram_addr/dout/doe/ceb/oeb/web <- bridge; i_sram_din -> bridge
// slave modport is the bridge; master modport is the CPU + SRAM environment.
interface sram_dmem_bridge_if #(parameter int ADDR_W = 19);
  logic [23:0]       i_daddr;
  logic [31:0]       i_dout;
  logic              i_ram_rd;
  logic [3:0]        i_ram_wr;
  logic [31:0]       o_din;
  logic              o_clk_en;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [7:0]        o_sram_dout;
  logic              o_sram_doe;
  logic [7:0]        i_sram_din;
  logic              o_sram_ceb;
  logic              o_sram_oeb;
  logic              o_sram_web;

  modport slave (
    input  i_daddr, i_dout, i_ram_rd, i_ram_wr, i_sram_din,
    output o_din, o_clk_en, o_sram_addr, o_sram_dout, o_sram_doe,
           o_sram_ceb, o_sram_oeb, o_sram_web
  );

  modport master (
    output i_daddr, i_dout, i_ram_rd, i_ram_wr, i_sram_din,
    input  o_din, o_clk_en, o_sram_addr, o_sram_dout, o_sram_doe,
           o_sram_ceb, o_sram_oeb, o_sram_web
  );
endinterface

// File: rtl/sram_dmem_bridge.sv
// Data-memory responder: serves single-cycle CPU load/store strobes against
// an 8-bit asynchronous SRAM one byte lane at a time, stalling the CPU via
// o_clk_en until the access completes.
// Ports:
//   i_clk  - sole clock
//   i_rstb - asynchronous active-low reset
//   bus    - sram_dmem_bridge_if.slave (CPU request/response + SRAM pins)
// Per lane: SETUP (address/ceb, 1 cycle) then STROBE (WAIT_STATES cycles).
module sram_dmem_bridge
  import sram_dmem_bridge_pkg::*;
#(
  parameter int ADDR_W      = 19,
  parameter int WAIT_STATES = 1
) (
  input  logic              i_clk,
  input  logic              i_rstb,
  sram_dmem_bridge_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES - 1);

  state_t                     state_q, state_d;
  logic [ADDR_W-3:0]          addr_q;
  logic [NUM_LANES-1:0]       mask_q;
  logic [31:0]                data_q;
  logic [31:0]                buf_q;
  logic [31:0]                din_q;
  logic                       wr_q;
  logic [1:0]                 lane_q;
  logic [CNT_W-1:0]           cnt_q;

  logic                       req;
  logic                       is_wr_req;
  logic                       strobe_end;
  logic [NUM_LANES-1:0]       mask_left;
  logic [7:0]                 lane_byte;

  assign is_wr_req  = |bus.i_ram_wr;
  assign req        = bus.i_ram_rd | is_wr_req;
  assign strobe_end = (state_q == ST_STROBE) && (cnt_q == '0);
  assign mask_left  = mask_q & ~(NUM_LANES'(1) << lane_q);
  assign lane_byte  = data_q[BYTE_W*lane_q +: BYTE_W];

  assign bus.o_sram_addr = {addr_q, lane_q};
  assign bus.o_din       = din_q;

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Pad controls are decoded from the registered state, so an async reset
  // releases every strobe in the same instant the state returns to IDLE.
  always_comb begin
    state_d         = state_q;
    bus.o_clk_en    = 1'b0;
    bus.o_sram_ceb  = 1'b1;
    bus.o_sram_oeb  = 1'b1;
    bus.o_sram_web  = 1'b1;
    bus.o_sram_doe  = 1'b0;
    bus.o_sram_dout = 8'h00;
    case (state_q)
      ST_IDLE: begin
        bus.o_clk_en = !req;
        if (req) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        bus.o_sram_ceb = 1'b0;
        if (wr_q) begin
          bus.o_sram_doe  = 1'b1;
          bus.o_sram_dout = lane_byte;
        end else begin
          bus.o_sram_oeb  = 1'b0;
        end
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        bus.o_sram_ceb = 1'b0;
        if (wr_q) begin
          bus.o_sram_doe  = 1'b1;
          bus.o_sram_dout = lane_byte;
          bus.o_sram_web  = 1'b0;
        end else begin
          bus.o_sram_oeb  = 1'b0;
        end
        if (cnt_q == '0) state_d = (mask_left != '0) ? ST_SETUP : ST_DONE;
      end
      ST_DONE: begin
        // This cycle's edge is also the CPU's next enabled edge.
        bus.o_clk_en = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      addr_q <= '0;
      mask_q <= '0;
      data_q <= '0;
      buf_q  <= '0;
      din_q  <= '0;
      wr_q   <= 1'b0;
      lane_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (req) begin
          // A store outranks a simultaneous load.
          addr_q <= bus.i_daddr[ADDR_W-1:2];
          wr_q   <= is_wr_req;
          mask_q <= is_wr_req ? bus.i_ram_wr : 4'hF;
          lane_q <= lowest_lane(is_wr_req ? bus.i_ram_wr : 4'hF);
          data_q <= bus.i_dout;
        end
        ST_SETUP: cnt_q <= CNT_INIT;
        ST_STROBE: begin
          if (strobe_end) begin
            mask_q <= mask_left;
            lane_q <= lowest_lane(mask_left);
            if (!wr_q) buf_q[BYTE_W*lane_q +: BYTE_W] <= bus.i_sram_din;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: if (!wr_q) din_q <= buf_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_dmem_bridge.sv
// Directed bench for sram_dmem_bridge with a behavioural SRAM and
// scoreboard queues of expected SRAM read/write accesses.
module tb_sram_dmem_bridge;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0]  mem [0:1023];
  wr_t         exp_wr [$];
  logic [31:0] exp_rd [$];

  logic        prev_web  = 1'b1;
  logic        prev_oeb  = 1'b1;
  logic [18:0] prev_addr = '0;

  sram_dmem_bridge_if #(.ADDR_W(19)) bus ();

  sram_dmem_bridge #(.ADDR_W(19), .WAIT_STATES(1)) dut (
    .i_clk  (clk),
    .i_rstb (rstb),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.i_sram_din = (!bus.o_sram_ceb && !bus.o_sram_oeb) ? mem[bus.o_sram_addr[9:0]] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // SRAM pin monitor: applies writes to the model and pops the scoreboard.
  always @(negedge clk) begin
    if (!bus.o_sram_ceb && !bus.o_sram_web) begin
      if (prev_web) begin
        chk("web_addr_stable", 32'(bus.o_sram_addr), 32'(prev_addr));
        chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.o_sram_addr), e.a);
          chk("wr_data", 32'(bus.o_sram_dout), 32'(e.d));
          chk("wr_doe", 32'(bus.o_sram_doe), 32'd1);
        end
      end
      mem[bus.o_sram_addr[9:0]] = bus.o_sram_dout;
    end
    if (!bus.o_sram_ceb && !bus.o_sram_oeb && (prev_oeb || bus.o_sram_addr != prev_addr)) begin
      chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) chk("rd_addr", 32'(bus.o_sram_addr), exp_rd.pop_front());
    end
    prev_web  = bus.o_sram_web;
    prev_oeb  = bus.o_sram_oeb;
    prev_addr = bus.o_sram_addr;
  end

  // Called just after a clock edge with the bridge in IDLE; returns just
  // after the DONE edge with the request withdrawn.
  task automatic run_req(input logic rd, input logic [3:0] wr, input logic [23:0] addr,
                         input logic [31:0] dout, input int exp_stall,
                         input logic [31:0] exp_din);
    logic [31:0] old;
    int stall;
    int held_bad;
    old = bus.o_din;
    stall = 0;
    held_bad = 0;
    bus.i_ram_rd = rd;
    bus.i_ram_wr = wr;
    bus.i_daddr  = addr;
    bus.i_dout   = dout;
    @(negedge clk);
    while (!bus.o_clk_en && stall < 64) begin
      stall++;
      if (bus.o_din !== old) held_bad++;
      @(negedge clk);
    end
    chk("stall_cycles", 32'(stall), 32'(exp_stall));
    chk("din_held_in_stall", 32'(held_bad), 32'd0);
    chk("din_before_done_edge", bus.o_din, old);
    @(posedge clk);
    #1;
    bus.i_ram_rd = 1'b0;
    bus.i_ram_wr = 4'h0;
    chk("din_after_done_edge", bus.o_din, exp_din);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h104] = 8'h11; mem[10'h105] = 8'h22; mem[10'h106] = 8'h33; mem[10'h107] = 8'h44;
    mem[10'h108] = 8'h55; mem[10'h109] = 8'h66; mem[10'h10A] = 8'h77; mem[10'h10B] = 8'h88;
    bus.i_ram_rd = 1'b0;
    bus.i_ram_wr = 4'h0;
    bus.i_daddr  = '0;
    bus.i_dout   = '0;

    // Reset values
    #12;
    chk("rst_clk_en", 32'(bus.o_clk_en), 32'd1);
    chk("rst_din", bus.o_din, 32'h0);
    chk("rst_addr", 32'(bus.o_sram_addr), 32'h0);
    chk("rst_strobes", {29'd0, bus.o_sram_ceb, bus.o_sram_oeb, bus.o_sram_web}, 32'h7);
    chk("rst_doe_dout", {23'd0, bus.o_sram_doe, bus.o_sram_dout}, 32'h0);
    #11 rstb = 1'b1;
    @(posedge clk); #1;

    // Word load at 0x104
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'h104 + 32'(i));
    run_req(1'b1, 4'h0, 24'h000104, 32'h0, 9, 32'h44332211);

    // Single-lane store
    exp_wr.push_back('{32'h202, 8'hAB});
    run_req(1'b0, 4'b0100, 24'h000200, 32'h00AB0000, 3, 32'h44332211);
    chk("mem_202", 32'(mem[10'h202]), 32'hAB);
    chk("mem_203_untouched", 32'(mem[10'h203]), 32'h00);

    // Non-contiguous store mask
    exp_wr.push_back('{32'h211, 8'hCC});
    exp_wr.push_back('{32'h213, 8'hDD});
    run_req(1'b0, 4'b1010, 24'h000210, 32'hDD00CC00, 5, 32'h44332211);
    chk("mem_210_untouched", 32'(mem[10'h210]), 32'h00);

    // Back-to-back loads A then B
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'h104 + 32'(i));
    run_req(1'b1, 4'h0, 24'h000104, 32'h0, 9, 32'h44332211);
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'h108 + 32'(i));
    run_req(1'b1, 4'h0, 24'h000108, 32'h0, 9, 32'h88776655);

    // Load and store together: store wins, no reads expected
    for (int i = 0; i < 4; i++) exp_wr.push_back('{32'h220 + 32'(i), 8'(i + 1)});
    run_req(1'b1, 4'hF, 24'h000220, 32'h04030201, 9, 32'h88776655);
    chk("mem_223", 32'(mem[10'h223]), 32'h04);

    // Reset during lane-2 strobe of a word store
    for (int i = 0; i < 4; i++) exp_wr.push_back('{32'h300 + 32'(i), 8'hA1 + 8'(i)});
    bus.i_ram_wr = 4'hF;
    bus.i_daddr  = 24'h000300;
    bus.i_dout   = 32'hA4A3A2A1;
    n = 0;
    @(negedge clk);
    while (!(bus.o_sram_web == 1'b0 && bus.o_sram_addr[1:0] == 2'd2) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("reach_lane2_strobe", 32'(n < 50), 32'd1);
    #2 rstb = 1'b0;
    #1;
    chk("abort_strobes", {29'd0, bus.o_sram_ceb, bus.o_sram_oeb, bus.o_sram_web}, 32'h7);
    chk("abort_doe", 32'(bus.o_sram_doe), 32'd0);
    chk("abort_clk_en_req", 32'(bus.o_clk_en), 32'd0);
    chk("abort_lane3_pending", 32'(exp_wr.size()), 32'd1);
    exp_wr.delete();
    bus.i_ram_wr = 4'h0;
    #1;
    chk("abort_clk_en_idle", 32'(bus.o_clk_en), 32'd1);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("post_rst_clk_en", 32'(bus.o_clk_en), 32'd1);
    chk("post_rst_din", bus.o_din, 32'h0);
    chk("post_rst_ceb", 32'(bus.o_sram_ceb), 32'd1);

    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
